// File: rtl/adj_scheduler.sv
// Shared UP/DOWN editor for four waveform settings with
// press-and-hold auto-repeat that accelerates the longer a button is held.
module adj_scheduler #(
  parameter int unsigned MS_DIV   = 100000,
  parameter int unsigned FREQ_MAX = 20000,
  parameter int unsigned FREQ_RST = 1000,
  parameter int unsigned AMP_FULL = 4095
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        UP,
  input  logic        DOWN,
  input  logic [1:0]  SEL,
  output logic [31:0] FREQ,
  output logic [31:0] MAX_AMP,
  output logic [31:0] MIN_AMP,
  output logic [31:0] DUTY,
  output logic [1:0]  ACTIVE_SEL,
  output logic        BUSY,
  output logic        LIMIT
);

  localparam logic [31:0] PRE_LAST = 32'(MS_DIV - 1);
  localparam logic [31:0] F_MAX    = 32'(FREQ_MAX);
  localparam logic [31:0] F_RST    = 32'(FREQ_RST);
  localparam logic [31:0] A_FULL   = 32'(AMP_FULL);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    LOCK
  } state_t;

  state_t state;
  state_t state_d;

  logic        dir_up;
  logic [31:0] pre_cnt;
  logic [9:0]  ms_cnt;
  logic [3:0]  sec_cnt;
  logic [9:0]  per_cnt;
  logic [9:0]  per_nxt;
  logic [9:0]  period;
  logic        ms_tick;

  logic        step;
  logic        latch;
  logic        held;
  logic        other;
  logic        up_s;
  logic [1:0]  tgt;
  logic [31:0] cur;
  logic [31:0] lo;
  logic [31:0] hi;
  logic [31:0] nxt;
  logic        blocked;

  assign ms_tick = (state != IDLE) && (pre_cnt == PRE_LAST);
  assign per_nxt = per_cnt + 10'd1;
  assign held    = dir_up ? UP : DOWN;
  assign other   = dir_up ? DOWN : UP;
  assign up_s    = latch ? UP : dir_up;
  assign tgt     = latch ? SEL : ACTIVE_SEL;

  // Repeat period in ms, indexed by whole seconds held
  always_comb begin
    period = 10'd2;
    unique case (1'b1)
      (sec_cnt <= 4'd1):                      period = 10'd500;
      (sec_cnt == 4'd2):                      period = 10'd125;
      (sec_cnt >= 4'd3 && sec_cnt <= 4'd4):   period = 10'd31;
      (sec_cnt >= 4'd5 && sec_cnt <= 4'd7):   period = 10'd8;
      (sec_cnt >= 4'd8):                      period = 10'd2;
    endcase
  end

  always_comb begin
    state_d = state;
    step    = 1'b0;
    latch   = 1'b0;
    unique case (state)
      IDLE: begin
        if (UP ^ DOWN) begin
          state_d = HOLD;
          step    = 1'b1;
          latch   = 1'b1;
        end else if (UP && DOWN) begin
          state_d = LOCK;
        end
      end
      HOLD: begin
        if (!held) begin
          state_d = IDLE;
        end else if (other) begin
          state_d = LOCK;
        end else if (ms_tick && per_nxt >= period) begin
          step = 1'b1;
        end
      end
      LOCK: begin
        if (!UP && !DOWN) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Limits are evaluated on the pre-step value, so no wrap is possible
  always_comb begin
    cur = '0;
    lo  = '0;
    hi  = '0;
    unique case (tgt)
      2'd0: begin
        cur = FREQ;
        lo  = 32'd1;
        hi  = F_MAX;
      end
      2'd1: begin
        cur = MAX_AMP;
        lo  = MIN_AMP;
        hi  = A_FULL;
      end
      2'd2: begin
        cur = MIN_AMP;
        lo  = '0;
        hi  = (MAX_AMP < A_FULL) ? MAX_AMP : A_FULL;
      end
      2'd3: begin
        cur = DUTY;
        lo  = '0;
        hi  = 32'd100;
      end
    endcase
    blocked = up_s ? (cur >= hi) : (cur <= lo);
    nxt     = up_s ? cur + 32'd1 : cur - 32'd1;
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      pre_cnt <= '0;
      ms_cnt  <= '0;
      sec_cnt <= '0;
      per_cnt <= '0;
    end else if (state == IDLE) begin
      pre_cnt <= '0;
      ms_cnt  <= '0;
      sec_cnt <= '0;
      per_cnt <= '0;
    end else if (ms_tick) begin
      pre_cnt <= '0;
      if (ms_cnt == 10'd999) begin
        ms_cnt <= '0;
        if (sec_cnt != 4'd15) begin
          sec_cnt <= sec_cnt + 4'd1;
        end
      end else begin
        ms_cnt <= ms_cnt + 10'd1;
      end
      if (state == HOLD) begin
        per_cnt <= step ? '0 : per_nxt;
      end
    end else begin
      pre_cnt <= pre_cnt + 32'd1;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      FREQ       <= F_RST;
      MAX_AMP    <= A_FULL;
      MIN_AMP    <= '0;
      DUTY       <= 32'd50;
      ACTIVE_SEL <= '0;
      dir_up     <= 1'b0;
      BUSY       <= 1'b0;
      LIMIT      <= 1'b0;
    end else begin
      BUSY  <= (state != IDLE);
      LIMIT <= step && blocked;
      if (latch) begin
        ACTIVE_SEL <= SEL;
        dir_up     <= UP;
      end
      if (step && !blocked) begin
        unique case (tgt)
          2'd0: FREQ    <= nxt;
          2'd1: MAX_AMP <= nxt;
          2'd2: MIN_AMP <= nxt;
          2'd3: DUTY    <= nxt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adj_scheduler.sv
// Bench for adj_scheduler: directed scenarios with literal expectations
// plus random button traffic, all checked against a behavioural model.
module tb_adj_scheduler;

  localparam int unsigned MS = 4;

  logic        CLOCK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        UP = 1'b0;
  logic        DOWN = 1'b0;
  logic [1:0]  SEL = 2'd0;
  logic [31:0] FREQ;
  logic [31:0] MAX_AMP;
  logic [31:0] MIN_AMP;
  logic [31:0] DUTY;
  logic [1:0]  ACTIVE_SEL;
  logic        BUSY;
  logic        LIMIT;

  int checks = 0;
  int failures = 0;
  int lim_cnt = 0;

  adj_scheduler #(
    .MS_DIV(MS)
  ) dut (
    .CLOCK(CLOCK),
    .RESET_N(RESET_N),
    .UP(UP),
    .DOWN(DOWN),
    .SEL(SEL),
    .FREQ(FREQ),
    .MAX_AMP(MAX_AMP),
    .MIN_AMP(MIN_AMP),
    .DUTY(DUTY),
    .ACTIVE_SEL(ACTIVE_SEL),
    .BUSY(BUSY),
    .LIMIT(LIMIT)
  );

  always #5 CLOCK = ~CLOCK;

  // Behavioural model: 0 idle, 1 holding, 2 locked
  int          m_st;
  bit          m_up;
  logic [1:0]  m_sel;
  int unsigned m_cyc;
  int unsigned m_last;
  logic [31:0] m_f;
  logic [31:0] m_mx;
  logic [31:0] m_mn;
  logic [31:0] m_d;
  bit          m_busy;
  bit          m_lim;
  bit          stp;
  bit          sup;
  logic [1:0]  stg;
  int unsigned ms_now;
  int unsigned secs;

  function automatic int unsigned period_ms(int unsigned s);
    if (s <= 1) return 500;
    if (s == 2) return 125;
    if (s <= 4) return 31;
    if (s <= 7) return 8;
    return 2;
  endfunction

  always @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_st = 0; m_up = 0; m_sel = 0; m_cyc = 0; m_last = 0;
      m_f = 1000; m_mx = 4095; m_mn = 0; m_d = 50;
      m_busy = 0; m_lim = 0;
    end else begin
      stp = 0;
      sup = m_up;
      stg = m_sel;
      m_busy = (m_st != 0);
      if (m_st == 0) begin
        if (UP != DOWN) begin
          m_sel = SEL; m_up = UP; sup = UP; stg = SEL;
          stp = 1; m_st = 1; m_cyc = 0; m_last = 0;
        end else if (UP && DOWN) begin
          m_st = 2;
        end
      end else if (m_st == 1) begin
        if (!(m_up ? UP : DOWN)) m_st = 0;
        else if (m_up ? DOWN : UP) m_st = 2;
        else begin
          m_cyc++;
          if (m_cyc % MS == 0) begin
            ms_now = m_cyc / MS;
            secs = (ms_now - 1) / 1000;
            if (secs > 15) secs = 15;
            if (ms_now - m_last >= period_ms(secs)) begin
              stp = 1;
              m_last = ms_now;
            end
          end
        end
      end else begin
        if (!UP && !DOWN) m_st = 0;
      end
      m_lim = 0;
      if (stp) begin
        case (stg)
          2'd0: if (sup) begin if (m_f < 20000) m_f++; else m_lim = 1; end
                else begin if (m_f > 1) m_f--; else m_lim = 1; end
          2'd1: if (sup) begin if (m_mx < 4095) m_mx++; else m_lim = 1; end
                else begin if (m_mx > m_mn) m_mx--; else m_lim = 1; end
          2'd2: if (sup) begin if (m_mn < m_mx && m_mn < 4095) m_mn++; else m_lim = 1; end
                else begin if (m_mn > 0) m_mn--; else m_lim = 1; end
          default: if (sup) begin if (m_d < 100) m_d++; else m_lim = 1; end
                   else begin if (m_d > 0) m_d--; else m_lim = 1; end
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLOCK) begin
    if (RESET_N) begin
      chk("freq", FREQ, m_f);
      chk("max_amp", MAX_AMP, m_mx);
      chk("min_amp", MIN_AMP, m_mn);
      chk("duty", DUTY, m_d);
      chk("active_sel", {30'd0, ACTIVE_SEL}, {30'd0, m_sel});
      chk("busy", {31'd0, BUSY}, {31'd0, m_busy});
      chk("limit", {31'd0, LIMIT}, {31'd0, m_lim});
      if (LIMIT) lim_cnt++;
    end
  end

  task automatic drive(input bit u, input bit d, input logic [1:0] s, input int n);
    UP = u;
    DOWN = d;
    SEL = s;
    repeat (n) @(negedge CLOCK);
  endtask

  initial begin
    repeat (3) @(negedge CLOCK);
    chk("rst_freq", FREQ, 1000);
    chk("rst_max", MAX_AMP, 4095);
    chk("rst_min", MIN_AMP, 0);
    chk("rst_duty", DUTY, 50);
    chk("rst_busy", {31'd0, BUSY}, 0);
    RESET_N = 1'b1;
    drive(0, 0, 0, 2);
    chk("idle_freq", FREQ, 1000);

    drive(1, 0, 3, 1);
    chk("duty_pulse", DUTY, 51);
    drive(0, 0, 3, 5);
    chk("duty_no_more", DUTY, 51);
    chk("busy_idle", {31'd0, BUSY}, 0);
    drive(1, 0, 3, 4400);
    chk("duty_hold", DUTY, 54);
    drive(0, 0, 3, 4);

    repeat (999) begin
      drive(0, 1, 0, 1);
      drive(0, 0, 0, 1);
    end
    chk("freq_floor", FREQ, 1);
    drive(0, 1, 0, 1);
    chk("freq_blocked", FREQ, 1);
    chk("limit_pulse", {31'd0, LIMIT}, 1);
    drive(0, 0, 0, 1);
    chk("limit_one", {31'd0, LIMIT}, 0);
    drive(0, 0, 0, 2);
    drive(1, 0, 0, 36000);
    chk("freq_accel", FREQ, 953);
    drive(0, 0, 0, 4);

    drive(0, 1, 1, 1);
    drive(0, 0, 1, 1);
    chk("max_4094", MAX_AMP, 4094);
    repeat (4094) begin
      drive(1, 0, 2, 1);
      drive(0, 0, 2, 1);
    end
    chk("min_4094", MIN_AMP, 4094);
    lim_cnt = 0;
    drive(1, 0, 2, 4400);
    drive(0, 0, 2, 2);
    chk("min_stuck", MIN_AMP, 4094);
    chk("limit_count", lim_cnt, 3);

    repeat (10) begin
      drive(0, 1, 2, 1);
      drive(0, 0, 2, 1);
    end
    chk("min_4084", MIN_AMP, 4084);
    drive(0, 1, 1, 10);
    chk("max_4093", MAX_AMP, 4093);
    drive(1, 1, 1, 3000);
    chk("lock_max", MAX_AMP, 4093);
    chk("lock_busy", {31'd0, BUSY}, 1);
    drive(0, 1, 1, 3000);
    chk("lock_half", MAX_AMP, 4093);
    drive(0, 0, 1, 3);
    chk("lock_exit_busy", {31'd0, BUSY}, 0);

    drive(1, 0, 1, 5);
    chk("selchg_start", MAX_AMP, 4094);
    drive(1, 0, 2, 2100);
    chk("selchg_max", MAX_AMP, 4095);
    chk("selchg_min", MIN_AMP, 4084);
    chk("selchg_asel", {30'd0, ACTIVE_SEL}, 1);
    RESET_N = 1'b0;
    #1;
    chk("mid_rst_freq", FREQ, 1000);
    chk("mid_rst_max", MAX_AMP, 4095);
    chk("mid_rst_min", MIN_AMP, 0);
    chk("mid_rst_duty", DUTY, 50);
    chk("mid_rst_asel", {30'd0, ACTIVE_SEL}, 0);
    chk("mid_rst_busy", {31'd0, BUSY}, 0);
    chk("mid_rst_limit", {31'd0, LIMIT}, 0);
    @(negedge CLOCK);
    UP = 0;
    @(negedge CLOCK);
    RESET_N = 1'b1;

    repeat (80) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), int'($urandom_range(1, 300)));
    end
    drive(0, 0, 0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
